// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enum, flag struct and opcode width.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  typedef struct packed {
    logic zero;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head entry is presented on pop_data while not empty.
module alu_rsp_fifo #(
  parameter int unsigned DW    = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers (natural wrap at power-of-2 depth) and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// ALU command responder: one-entry exec stage feeding an in-order response FIFO.
// Optional build macro ALU_RSP_TAG_EN adds cmd_tag/rsp_tag that travel with each command.
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned TAG_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry
`ifdef ALU_RSP_TAG_EN
  ,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [TAG_W-1:0] rsp_tag
`endif
);

`ifdef ALU_RSP_TAG_EN
  localparam int unsigned TAG_BITS = TAG_W;
`else
  // Tag field compiled out; width collapses to zero.
  localparam int unsigned TAG_BITS = TAG_W - TAG_W;
`endif
  localparam int unsigned DW    = WIDTH + 2 + TAG_BITS;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  logic             exec_valid;
  logic [WIDTH-1:0] exec_a;
  logic [WIDTH-1:0] exec_b;
  op_t              exec_op;
  logic             accept;

  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_result;
  alu_flags_t       alu_flags;

  logic [DW-1:0]    fifo_wdata;
  logic [DW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  alu_flags_t       rsp_flags;

  assign accept = cmd_valid & cmd_ready;
  // Room check from registered state only: the exec entry will claim one FIFO slot.
  assign cmd_ready = exec_valid ? (fifo_count < CNT_W'(RSP_DEPTH - 1)) : ~fifo_full;

  // Exec stage: latch operands on accept; it always drains into the FIFO next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid <= 1'b0;
      exec_a     <= '0;
      exec_b     <= '0;
      exec_op    <= OP_ADD;
    end else begin
      exec_valid <= accept;
      if (accept) begin
        exec_a  <= cmd_a;
        exec_b  <= cmd_b;
        exec_op <= op_t'(cmd_op);
      end
    end
  end

`ifdef ALU_RSP_TAG_EN
  logic [TAG_W-1:0] exec_tag;

  // Tag rides alongside the exec operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         exec_tag <= '0;
    else if (accept) exec_tag <= cmd_tag;
  end

  assign fifo_wdata = {exec_tag, alu_result, alu_flags};
  assign {rsp_tag, rsp_result, rsp_flags} = fifo_rdata;
`else
  assign fifo_wdata = {alu_result, alu_flags};
  assign {rsp_result, rsp_flags} = fifo_rdata;
`endif

  // ALU: arithmetic at WIDTH+1 bits so bit WIDTH is the carry / borrow.
  always_comb begin
    alu_wide        = '0;
    alu_result      = '0;
    alu_flags       = '0;
    case (exec_op)
      OP_ADD: begin
        alu_wide        = {1'b0, exec_a} + {1'b0, exec_b};
        alu_result      = alu_wide[WIDTH-1:0];
        alu_flags.carry = alu_wide[WIDTH];
      end
      OP_SUB: begin
        alu_wide        = {1'b0, exec_a} - {1'b0, exec_b};
        alu_result      = alu_wide[WIDTH-1:0];
        alu_flags.carry = alu_wide[WIDTH];
      end
      OP_AND:  alu_result = exec_a & exec_b;
      OP_OR:   alu_result = exec_a | exec_b;
      OP_XOR:  alu_result = exec_a ^ exec_b;
      OP_NOT:  alu_result = ~exec_a;
      OP_SHL:  alu_result = exec_a << 1;
      OP_SHR:  alu_result = exec_a >> 1;
      default: alu_result = '0;
    endcase
    alu_flags.zero = (alu_result == '0);
  end

  alu_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (exec_valid),
    .push_data (fifo_wdata),
    .pop       (rsp_valid & rsp_ready),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_zero  = rsp_flags.zero;
  assign rsp_carry = rsp_flags.carry;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder (build with or without ALU_RSP_TAG_EN).
module tb_alu_cmd_responder;

  localparam int W   = 4;
  localparam int D   = 2;
  localparam int TW  = 2;
  localparam int MOD = 1 << W;
`ifdef ALU_RSP_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [2:0]    cmd_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero;
  logic          rsp_carry;
  logic [TW-1:0] cmd_tag;
  logic [TW-1:0] rsp_tag;

  alu_cmd_responder #(.WIDTH(W), .RSP_DEPTH(D), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry)
`ifdef ALU_RSP_TAG_EN
    ,
    .cmd_tag    (cmd_tag),
    .rsp_tag    (rsp_tag)
`endif
  );

`ifndef ALU_RSP_TAG_EN
  assign rsp_tag = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int result;
    int zero;
    int carry;
    int tag;
    int vis;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    int           r;
    int           z;
    int           c;
  } vec_t;

  exp_t sbq[$];
  exp_t pending;
  int   checks;
  int   errors;
  int   cyc;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference ALU written from the opcode rules with plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int op, input int tag);
    exp_t e;
    int   s;
    e.carry = 0;
    case (op)
      0: begin s = a + b; e.result = s % MOD; e.carry = (s >= MOD) ? 1 : 0; end
      1: begin e.result = (a - b + MOD) % MOD; e.carry = (a < b) ? 1 : 0; end
      2: e.result = a & b;
      3: e.result = a | b;
      4: e.result = a ^ b;
      5: e.result = (MOD - 1) - a;
      6: e.result = (a * 2) % MOD;
      default: e.result = a / 2;
    endcase
    e.zero = (e.result == 0) ? 1 : 0;
    e.tag  = TAG_EN ? tag : 0;
    e.vis  = 0;
    return e;
  endfunction

  task automatic set_cmd(input int a, input int b, input int op, input int tag);
    cmd_a   = W'(a);
    cmd_b   = W'(b);
    cmd_op  = 3'(op);
    cmd_tag = TW'(tag);
    pending = model(a, b, op, tag);
  endtask

  // One clock: compare outputs with the transaction-level model, then advance.
  // Model: outstanding (accepted, not yet popped) < D gives ready; the oldest entry
  // becomes visible two edges after the edge that accepted it was scheduled.
  task automatic step(output bit acc, output bit popped);
    bit exp_ready;
    bit exp_valid;
    exp_ready = (sbq.size() < D);
    exp_valid = (sbq.size() > 0) && (cyc >= sbq[0].vis);
    check("cmd_ready", int'(cmd_ready), int'(exp_ready));
    check("rsp_valid", int'(rsp_valid), int'(exp_valid));
    if (exp_valid) begin
      check("rsp_result", int'(rsp_result), sbq[0].result);
      check("rsp_zero",   int'(rsp_zero),   sbq[0].zero);
      check("rsp_carry",  int'(rsp_carry),  sbq[0].carry);
      check("rsp_tag",    int'(rsp_tag),    sbq[0].tag);
    end
    popped = exp_valid && rsp_ready;
    acc    = cmd_valid && exp_ready;
    if (popped) void'(sbq.pop_front());
    if (acc) begin
      pending.vis = cyc + 2;
      sbq.push_back(pending);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit a;
    bit p;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step(a, p);
    step(a, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    bit   acc;
    bit   pop;
    int   ca[3];
    int   cb[3];
    int   co[3];
    int   k;
    int   dut_acc;
    int   pop1;
    int   acc3;
    int   n;

    checks = 0;
    errors = 0;
    cyc    = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    pending = model(0, 0, 0, 0);

    tbl[0]  = '{4'd10, 4'd5,  3'd0, 15, 0, 0};
    tbl[1]  = '{4'd15, 4'd3,  3'd1, 12, 0, 0};
    tbl[2]  = '{4'd3,  4'd5,  3'd1, 14, 0, 1};
    tbl[3]  = '{4'd15, 4'd1,  3'd0, 0,  1, 1};
    tbl[4]  = '{4'd12, 4'd15, 3'd2, 12, 0, 0};
    tbl[5]  = '{4'd5,  4'd10, 3'd3, 15, 0, 0};
    tbl[6]  = '{4'd9,  4'd9,  3'd4, 0,  1, 0};
    tbl[7]  = '{4'd5,  4'd0,  3'd5, 10, 0, 0};
    tbl[8]  = '{4'd9,  4'd0,  3'd6, 2,  0, 0};
    tbl[9]  = '{4'd9,  4'd0,  3'd7, 4,  0, 0};
    tbl[10] = '{4'd1,  4'd0,  3'd7, 0,  1, 0};
    tbl[11] = '{4'd7,  4'd7,  3'd1, 0,  1, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_result",    int'(rsp_result), 0);
    check("rst_zero",      int'(rsp_zero), 0);
    check("rst_carry",     int'(rsp_carry), 0);
    check("rst_tag",       int'(rsp_tag), 0);
    rst = 1'b0;

    // Directed vectors, one command at a time with the consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cmd_a = tbl[i].a; cmd_b = tbl[i].b; cmd_op = tbl[i].op; cmd_tag = '0;
      pending = '{result: tbl[i].r, zero: tbl[i].z, carry: tbl[i].c, tag: 0, vis: 0};
      cmd_valid = 1'b1;
      step(acc, pop);
      cmd_valid = 1'b0;
      repeat (3) step(acc, pop);
    end

    // Back-pressure: three commands held with the consumer stalled.
    ca = '{1, 9, 6}; cb = '{2, 4, 3}; co = '{0, 1, 4};
    k = 0; dut_acc = 0;
    rsp_ready = 1'b0;
    set_cmd(ca[0], cb[0], co[0], 0);
    cmd_valid = 1'b1;
    repeat (6) begin
      if (cmd_valid && cmd_ready) dut_acc++;
      step(acc, pop);
      if (acc) begin
        k++;
        if (k < 3) set_cmd(ca[k], cb[k], co[k], k);
        else cmd_valid = 1'b0;
      end
    end
    check("held_accepts", dut_acc, 2);
    rsp_ready = 1'b1;
    pop1 = -1; acc3 = -100;
    for (int i = 0; i < 20 && (k < 3 || sbq.size() > 0); i++) begin
      if (rsp_valid && rsp_ready && pop1 < 0) pop1 = cyc;
      if (cmd_valid && cmd_ready && k == 2) acc3 = cyc;
      step(acc, pop);
      if (acc) begin
        k++;
        if (k == 3) cmd_valid = 1'b0;
      end
    end
    check("third_accept_gap", acc3 - pop1, 1);
    drain();

    // Fill the FIFO, then stream 8 commands with the consumer ready.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    set_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 0);
    repeat (4) begin
      step(acc, pop);
      if (acc) set_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 0);
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      if (cmd_valid && cmd_ready) n++;
      step(acc, pop);
      if (acc) begin
        if (n < 8) set_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        else cmd_valid = 1'b0;
      end
    end
    check("stream_accepts", n, 8);
    drain();

    // Randomised traffic on both channels.
    cmd_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!cmd_valid || acc) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        set_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step(acc, pop);
    end
    drain();

    // Reset with one queued response and one in the exec stage.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    set_cmd(3, 4, 0, 1);
    step(acc, pop);
    set_cmd(8, 1, 1, 2);
    step(acc, pop);
    cmd_valid = 1'b0;
    check("pre_rst_valid", int'(rsp_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  int'(rsp_valid), 0);
    check("mid_rst_ready",  int'(cmd_ready), 1);
    check("mid_rst_result", int'(rsp_result), 0);
    check("mid_rst_tag",    int'(rsp_tag), 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    rsp_ready = 1'b1;
    repeat (5) step(acc, pop);

    // Tags 0..3 return with their own commands.
    for (int t = 0; t < 4; t++) begin
      set_cmd(t + 2, t, t, t);
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step(acc, pop);
        if (acc) break;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
